// File: rtl/jpeg_dq_pkg.sv
// Shared definitions for the JPEG column dequantizer: default Q table,
// width defaults and lane packing helpers.
package jpeg_dq_pkg;

  localparam int COEF_W_DEF = 10;
  localparam int LANES      = 8;

  // Default Q table, index row*8 + col; Q = round(128/recip) of the encoder side.
  localparam logic [7:0] QT_DEFAULT [64] = '{
    8'd4,   8'd3,  8'd3,  8'd4,  8'd6,  8'd10, 8'd13, 8'd15,
    8'd13,  8'd3,  8'd4,  8'd5,  8'd7,  8'd15, 8'd15, 8'd14,
    8'd14,  8'd4,  8'd4,  8'd6,  8'd10, 8'd14, 8'd17, 8'd14,
    8'd14,  8'd5,  8'd6,  8'd7,  8'd13, 8'd22, 8'd20, 8'd16,
    8'd18,  8'd6,  8'd9,  8'd14, 8'd17, 8'd27, 8'd26, 8'd19,
    8'd26,  8'd9,  8'd14, 8'd16, 8'd20, 8'd26, 8'd28, 8'd23,
    8'd64,  8'd16, 8'd20, 8'd22, 8'd26, 8'd30, 8'd30, 8'd25,
    8'd128, 8'd23, 8'd24, 8'd24, 8'd28, 8'd25, 8'd26, 8'd25
  };

  // Extract signed input lane idx; lane 0 sits in the MSBs.
  function automatic logic signed [7:0] in_lane(input logic [63:0] d, input int idx);
    return d[63-8*idx -: 8];
  endfunction

  // Flat Q-table address of entry (row, col).
  function automatic logic [5:0] qt_index(input logic [2:0] row, input logic [2:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/dequant_lane.sv
// One dequantizer lane: signed 8-bit coefficient times unsigned Q entry,
// saturated to a signed COEF_W result with a saturation flag.
module dequant_lane #(
  parameter int COEF_W = 10,
  parameter int Q_W    = 8
) (
  input  logic signed [7:0]        coef,
  input  logic        [Q_W-1:0]    q,
  output logic signed [COEF_W-1:0] res,
  output logic                     sat
);

  localparam int P_W = 8 + Q_W + 1;
  localparam logic signed [P_W-1:0] SAT_MAX = P_W'((1 << (COEF_W - 1)) - 1);
  localparam logic signed [P_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [P_W-1:0] coef_ext_s;
  logic signed [P_W-1:0] q_ext_s;
  logic signed [P_W-1:0] prod_s;

  assign coef_ext_s = {{(Q_W + 1){coef[7]}}, coef};
  assign q_ext_s    = $signed({{9{1'b0}}, q});
  assign prod_s     = coef_ext_s * q_ext_s;

  // Clamp the full-precision product into the output range.
  always_comb begin
    res = prod_s[COEF_W-1:0];
    sat = 1'b0;
    if (prod_s > SAT_MAX) begin
      res = SAT_MAX[COEF_W-1:0];
      sat = 1'b1;
    end else if (prod_s < SAT_MIN) begin
      res = SAT_MIN[COEF_W-1:0];
      sat = 1'b1;
    end else begin
      res = prod_s[COEF_W-1:0];
      sat = 1'b0;
    end
  end

endmodule

// File: rtl/dequantization_col.sv
// JPEG decoder-side column dequantizer: 8 lanes per beat, 2-stage pipeline
// with valid/ready on both sides and a runtime-writable Q table.
module dequantization_col
  import jpeg_dq_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEF,
  parameter int Q_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sof,
  input  logic [63:0]           in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*COEF_W-1:0]   out_data,
  output logic [2:0]            out_col,
  output logic                  out_last,
  output logic                  out_sat,
  output logic                  sync_err,
  input  logic                  qt_we,
  input  logic [5:0]            qt_addr,
  input  logic [Q_W-1:0]        qt_data
);

  logic                       adv1_s;
  logic                       adv2_s;
  logic                       acc_s;
  logic [2:0]                 col_s;
  logic [2:0]                 cnt_r;
  logic [Q_W-1:0]             qt_r [64];
  logic                       s1_valid_r;
  logic [63:0]                s1_data_r;
  logic [2:0]                 s1_col_r;
  logic [Q_W-1:0]             s1_q_r [LANES];
  logic signed [COEF_W-1:0]   lane_res_s [LANES];
  logic [LANES-1:0]           lane_sat_s;
  logic [8*COEF_W-1:0]        out_data_s;

  assign adv2_s   = !out_valid || out_ready;
  assign adv1_s   = !s1_valid_r || adv2_s;
  assign in_ready = adv1_s;
  assign acc_s    = in_valid && adv1_s;

  // Column of the incoming beat: start of frame forces column 0.
  always_comb begin
    col_s = cnt_r;
    if (in_sof) begin
      col_s = 3'd0;
    end else begin
      col_s = cnt_r;
    end
  end

  // Column counter and sticky resync error, advanced only by accepted beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r    <= 3'd0;
      sync_err <= 1'b0;
    end else if (acc_s) begin
      cnt_r <= col_s + 3'd1;
      if (in_sof && (cnt_r != 3'd0)) begin
        sync_err <= 1'b1;
      end
    end
  end

  // Q table storage; a write lands after this cycle's stage-1 read.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) begin
        qt_r[i] <= Q_W'(QT_DEFAULT[i]);
      end
    end else if (qt_we) begin
      qt_r[qt_addr] <= qt_data;
    end
  end

  // Stage 1: capture the beat, its column and the column's 8 Q entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= 64'd0;
      s1_col_r   <= 3'd0;
      for (int r = 0; r < LANES; r++) begin
        s1_q_r[r] <= '0;
      end
    end else if (adv1_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_data_r <= in_data;
        s1_col_r  <= col_s;
        for (int r = 0; r < LANES; r++) begin
          s1_q_r[r] <= qt_r[qt_index(3'(r), col_s)];
        end
      end
    end
  end

  for (genvar r = 0; r < LANES; r++) begin : g_lane
    dequant_lane #(
      .COEF_W (COEF_W),
      .Q_W    (Q_W)
    ) u_lane (
      .coef (in_lane(s1_data_r, r)),
      .q    (s1_q_r[r]),
      .res  (lane_res_s[r]),
      .sat  (lane_sat_s[r])
    );
  end

  // Pack lane results, lane 0 in the MSBs.
  always_comb begin
    out_data_s = '0;
    for (int r = 0; r < LANES; r++) begin
      out_data_s[8*COEF_W-1-COEF_W*r -: COEF_W] = lane_res_s[r];
    end
  end

  // Stage 2 / output register: loads when downstream can take a new beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_col   <= 3'd0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else if (adv2_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        out_data <= out_data_s;
        out_col  <= s1_col_r;
        out_last <= (s1_col_r == 3'd7);
        out_sat  <= |lane_sat_s;
      end
    end
  end

endmodule

// File: tb/tb_dequantization_col.sv
// Randomized self-checking bench for dequantization_col against a
// transaction-level model (Q table array + expected-beat queue).
module tb_dequantization_col;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sof;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [79:0] out_data;
  logic [2:0]  out_col;
  logic        out_last;
  logic        out_sat;
  logic        sync_err;
  logic        qt_we;
  logic [5:0]  qt_addr;
  logic [7:0]  qt_data;

  dequantization_col dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_col   (out_col),
    .out_last  (out_last),
    .out_sat   (out_sat),
    .sync_err  (sync_err),
    .qt_we     (qt_we),
    .qt_addr   (qt_addr),
    .qt_data   (qt_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] data;
    logic [2:0]  col;
    logic        last;
    logic        sat;
    int          stamp;
  } beat_t;

  int qdef[64] = '{
    4,   3,  3,  4,  6, 10, 13, 15,
    13,  3,  4,  5,  7, 15, 15, 14,
    14,  4,  4,  6, 10, 14, 17, 14,
    14,  5,  6,  7, 13, 22, 20, 16,
    18,  6,  9, 14, 17, 27, 26, 19,
    26,  9, 14, 16, 20, 26, 28, 23,
    64, 16, 20, 22, 26, 30, 30, 25,
    128, 23, 24, 24, 28, 25, 26, 25
  };

  beat_t sbq[$];
  int    qm[64];
  int    cnt_m;
  bit    serr_m;
  int    cyc;
  int    last_pop;
  bit    front_seen;
  bit    last_acc;
  int    total;
  int    bad;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: sample/check before the rising edge, then advance the model.
  task automatic step();
    beat_t e;
    bit rdy;
    int col;
    int p;
    int exp_cyc;
    logic signed [7:0] lv;
    #2;
    cyc++;
    rdy = (sbq.size() < 2) || out_ready;
    chk("in_ready", in_ready, rdy);
    chk("sync_err", sync_err, serr_m);
    if (out_valid) begin
      if (sbq.size() == 0) begin
        chk("spurious", out_valid, 1'b0);
      end else begin
        e = sbq[0];
        if (!front_seen) begin
          exp_cyc = (e.stamp + 2 > last_pop + 1) ? e.stamp + 2 : last_pop + 1;
          chk("latency", cyc, exp_cyc);
          front_seen = 1'b1;
        end
        chk("beat", {out_data, out_col, out_last, out_sat}, {e.data, e.col, e.last, e.sat});
        if (out_ready) begin
          void'(sbq.pop_front());
          last_pop   = cyc;
          front_seen = 1'b0;
        end
      end
    end
    last_acc = in_valid && rdy && !reset;
    if (last_acc) begin
      col = in_sof ? 0 : cnt_m;
      if (in_sof && cnt_m != 0) serr_m = 1'b1;
      cnt_m = (col + 1) % 8;
      e.col   = 3'(col);
      e.last  = (col == 7);
      e.sat   = 1'b0;
      e.data  = '0;
      e.stamp = cyc;
      for (int r = 0; r < 8; r++) begin
        lv = in_data[63-8*r -: 8];
        p  = int'(lv) * qm[r*8+col];
        if (p > 511) begin p = 511; e.sat = 1'b1; end
        if (p < -512) begin p = -512; e.sat = 1'b1; end
        e.data[79-10*r -: 10] = 10'(p);
      end
      sbq.push_back(e);
    end
    if (qt_we && !reset) qm[qt_addr] = int'(qt_data);
    if (reset) begin
      sbq.delete();
      for (int i = 0; i < 64; i++) qm[i] = qdef[i];
      cnt_m      = 0;
      serr_m     = 1'b0;
      front_seen = 1'b0;
      last_pop   = -100;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Send one 8-beat block; beat 0 carries lane0=l0 and optionally a Q write to addr 0.
  task automatic blk(input logic [7:0] l0, input bit wq, input logic [7:0] wd);
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      in_sof   = (c == 0);
      in_data  = (c == 0) ? {l0, 56'd0} : {$urandom(), $urandom()};
      qt_we    = wq && (c == 0);
      qt_addr  = 6'd0;
      qt_data  = wd;
      last_acc = 1'b0;
      for (int t = 0; t < 20 && !last_acc; t++) step();
      qt_we = 1'b0;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; cyc = 0; last_pop = -100; front_seen = 1'b0;
    cnt_m = 0; serr_m = 1'b0;
    for (int i = 0; i < 64; i++) qm[i] = qdef[i];
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = 64'd0;
    out_ready = 1'b1; qt_we = 1'b0; qt_addr = 6'd0; qt_data = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step();
    reset = 1'b0;
    chk("rst_state", {out_valid, out_data, out_col, out_last, out_sat, sync_err, in_ready}, 128'd1);

    // T1: single sof beat, lane0=+3 lane1=-2
    in_valid = 1'b1; in_sof = 1'b1; in_data = {8'h03, 8'hFE, 48'd0};
    step();
    in_valid = 1'b0; in_sof = 1'b0;
    step();
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_lane0", out_data[79:70], 10'd12);
    chk("t1_lane1", out_data[69:60], 10'h3E6);
    chk("t1_col", out_col, 3'd0);
    repeat (7) begin
      in_valid = 1'b1; in_data = {$urandom(), $urandom()};
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();

    // T2: back-to-back block
    blk(8'h11, 1'b0, 8'd0);
    repeat (3) step();

    // T3: saturation around Q=4 and Q=255
    blk(8'h80, 1'b0, 8'd0);
    qt_we = 1'b1; qt_addr = 6'd0; qt_data = 8'd255;
    step();
    qt_we = 1'b0;
    blk(8'h7F, 1'b0, 8'd0);
    blk(8'h80, 1'b0, 8'd0);
    repeat (3) step();

    // T4: downstream stall for 5 cycles mid-stream
    for (int i = 0; i < 14; i++) begin
      in_valid  = 1'b1; in_sof = 1'b0; in_data = {$urandom(), $urandom()};
      out_ready = !(i >= 3 && i < 8);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();

    // T5: sof on 4th beat, then reset mid-stream
    for (int t = 0; t < 10 && cnt_m != 0; t++) begin
      in_valid = 1'b1; in_data = {$urandom(), $urandom()};
      step();
    end
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_sof = (c == 0 || c == 3); in_data = {$urandom(), $urandom()};
      step();
    end
    in_sof = 1'b0;
    repeat (3) begin in_data = {$urandom(), $urandom()}; step(); end
    chk("t5_serr", sync_err, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    chk("t5_rst_ov", out_valid, 1'b0);
    chk("t5_rst_serr", sync_err, 1'b0);
    blk(8'h05, 1'b0, 8'd0);
    repeat (3) step();

    // T6: Q write coinciding with the col-0 beat that reads it
    blk(8'h0A, 1'b1, 8'd7);
    blk(8'h0A, 1'b0, 8'd0);
    repeat (3) step();

    // Random traffic with random backpressure and table writes
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sof    = (cnt_m == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 60) == 0);
      in_data   = {$urandom(), $urandom()};
      out_ready = ($urandom_range(0, 3) != 0);
      qt_we     = ($urandom_range(0, 7) == 0);
      qt_addr   = 6'($urandom_range(0, 63));
      qt_data   = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      step();
    end
    in_valid = 1'b0; in_sof = 1'b0; qt_we = 1'b0; out_ready = 1'b1;
    repeat (6) step();
    chk("drain", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
